// File: rtl/game_collision_scan.sv
// Scans one player box against n_objects target boxes, one object per clock, and reports
// hit mask, hit count, lowest hit index and a done pulse. Optional macro: GAME_COLLISION_STICKY_EN.
module game_collision_scan #(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int n_objects     = 4,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int w_idx         = (n_objects > 1) ? $clog2(n_objects) : 1,
    parameter int w_cnt         = $clog2(n_objects + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     hit_clear,
    input  logic [w_x-1:0]           p_left,
    input  logic [w_x-1:0]           p_right,
    input  logic [w_y-1:0]           p_top,
    input  logic [w_y-1:0]           p_bottom,
    input  logic [n_objects*w_x-1:0] obj_left,
    input  logic [n_objects*w_x-1:0] obj_right,
    input  logic [n_objects*w_y-1:0] obj_top,
    input  logic [n_objects*w_y-1:0] obj_bottom,
    input  logic [n_objects-1:0]     obj_enable,
    output logic                     busy,
    output logic                     done,
    output logic [n_objects-1:0]     hit_mask,
    output logic                     any_hit,
    output logic [w_cnt-1:0]         hit_count,
    output logic [w_idx-1:0]         first_hit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [w_idx-1:0] LAST_IDX = w_idx'(n_objects - 1);

    state_t               state_q, state_d;
    logic [w_idx-1:0]     idx_q, idx_d;
    logic [w_x-1:0]       pl_q, pl_d, pr_q, pr_d;
    logic [w_y-1:0]       pt_q, pt_d, pb_q, pb_d;
    logic [n_objects-1:0] en_q, en_d;
    logic [n_objects-1:0] shadow_q, shadow_d;
    logic [n_objects-1:0] mask_q, mask_d;
    logic                 any_q, any_d;
    logic [w_cnt-1:0]     cnt_q, cnt_d;
    logic [w_idx-1:0]     first_q, first_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 hit_s;

    function automatic logic box_overlap(
        input logic [w_x-1:0] al, input logic [w_x-1:0] ar,
        input logic [w_y-1:0] at, input logic [w_y-1:0] ab,
        input logic [w_x-1:0] bl, input logic [w_x-1:0] br,
        input logic [w_y-1:0] bt, input logic [w_y-1:0] bb
    );
        logic malformed;
        malformed   = (ar < al) | (ab < at) | (br < bl) | (bb < bt);
        box_overlap = !malformed && !((ar < bl) | (br < al) | (ab < bt) | (bb < at));
    endfunction

    function automatic logic [w_cnt-1:0] popcount(input logic [n_objects-1:0] m);
        logic [w_cnt-1:0] c;
        c = '0;
        for (int i = 0; i < n_objects; i++) begin
            c = c + w_cnt'(m[i]);
        end
        return c;
    endfunction

    function automatic logic [w_idx-1:0] lowest_set(input logic [n_objects-1:0] m);
        logic [w_idx-1:0] r;
        r = '0;
        for (int i = n_objects - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = w_idx'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Overlap test for the object currently selected by the scan index
    always_comb begin
        hit_s = en_q[idx_q] & box_overlap(pl_q, pr_q, pt_q, pb_q,
                                          obj_left[int'(idx_q)*w_x +: w_x],
                                          obj_right[int'(idx_q)*w_x +: w_x],
                                          obj_top[int'(idx_q)*w_y +: w_y],
                                          obj_bottom[int'(idx_q)*w_y +: w_y]);
    end

`ifndef GAME_COLLISION_STICKY_EN
    logic unused_hit_clear_s;
    assign unused_hit_clear_s = hit_clear;
`endif

    // Next-state, snapshot, shadow-mask and result computation
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pl_d     = pl_q;
        pr_d     = pr_q;
        pt_d     = pt_q;
        pb_d     = pb_q;
        en_d     = en_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        case (state_q)
            ST_IDLE: begin
`ifdef GAME_COLLISION_STICKY_EN
                if (hit_clear) begin
                    mask_d = '0;
                end else begin
                    mask_d = mask_q;
                end
`endif
                if (start) begin
                    state_d  = ST_SCAN;
                    idx_d    = '0;
                    pl_d     = p_left;
                    pr_d     = p_right;
                    pt_d     = p_top;
                    pb_d     = p_bottom;
                    en_d     = obj_enable;
                    shadow_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                shadow_d[idx_q] = hit_s;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
`ifdef GAME_COLLISION_STICKY_EN
                    // a clear on the load edge lets the fresh scan replace history
                    mask_d = hit_clear ? shadow_d : (mask_q | shadow_d);
`else
                    mask_d = shadow_d;
`endif
                end else begin
                    idx_d = idx_q + w_idx'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        any_d   = |mask_d;
        cnt_d   = popcount(mask_d);
        first_d = lowest_set(mask_d);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, snapshot and registered output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            pl_q     <= '0;
            pr_q     <= '0;
            pt_q     <= '0;
            pb_q     <= '0;
            en_q     <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            any_q    <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pl_q     <= pl_d;
            pr_q     <= pr_d;
            pt_q     <= pt_d;
            pb_q     <= pb_d;
            en_q     <= en_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            any_q    <= any_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign hit_mask      = mask_q;
    assign any_hit       = any_q;
    assign hit_count     = cnt_q;
    assign first_hit_idx = first_q;

endmodule
